// File: rtl/run_controller_pkg.sv
// Shared state encoding and halt-detection mode constants for the run controller.
package run_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, HOLD, RUN, DONE, TIMEOUT} run_state_e;

    localparam int MODE_PC_STABLE = 0;
    localparam int MODE_HALT_PC   = 1;

    // Hold counter is wide enough for the largest legal RESET_CYCLES (255).
    localparam int HOLD_W = 8;

    function automatic int stb_width(input int halt_cycles);
        return (halt_cycles < 2) ? 1 : $clog2(halt_cycles + 1);
    endfunction
endpackage

// File: rtl/run_controller_if.sv
// Control/status bundle between a host (master) and the run controller (slave).
interface run_controller_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic [PC_W-1:0]  pc;
    logic             retire;
    logic             core_reset;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output start, pc, retire,
        input  core_reset, running, done, timeout, cycle_count, retired_count
    );

    modport slave (
        input  start, pc, retire,
        output core_reset, running, done, timeout, cycle_count, retired_count
    );
endinterface

// File: rtl/run_controller_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 q <= '0;
        else if (clr)              q <= '0;
        else if (en && (q != '1))  q <= q + W'(1);
    end
endmodule

// File: rtl/run_controller.sv
// Launches a core out of reset, watches it run, and stops it on halt or cycle budget.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter int              CNT_W        = 32,
    parameter int              RESET_CYCLES = 2,
    parameter int              MAX_CYCLES   = 5000,
    parameter int              HALT_MODE    = 0,
    parameter int              HALT_CYCLES  = 4,
    parameter logic [PC_W-1:0] HALT_PC      = '0
) (
    input  logic             clk,
    input  logic             reset,
    run_controller_if.slave  bus
);
    localparam int STB_W = stb_width(HALT_CYCLES);

    run_state_e        st, nxt;
    logic              start_acc, in_run, in_hold, first_run, pc_same;
    logic              halt_hit, budget_hit, hold_end;
    logic [PC_W-1:0]   prev_pc;
    logic [HOLD_W-1:0] hold_q;
    logic [STB_W-1:0]  stb_q;
    logic [CNT_W-1:0]  cyc_q, ret_q;
    logic              core_reset_q, running_q, done_q, timeout_q;

    assign in_run  = (st == RUN);
    assign in_hold = (st == HOLD);
    // Counters clear on launch, so a zero cycle count marks the first RUN cycle,
    // whose prev_pc is stale and must never count as stable.
    assign first_run  = (cyc_q == '0);
    assign pc_same    = !first_run && (bus.pc == prev_pc);
    assign budget_hit = (cyc_q == CNT_W'(MAX_CYCLES - 1));
    assign hold_end   = (hold_q == HOLD_W'(RESET_CYCLES - 1));

    // Halt/budget fire in the cycle whose counter update reaches the limit.
    always_comb begin
        halt_hit = 1'b0;
        if (HALT_MODE == MODE_HALT_PC)
            halt_hit = bus.retire && (bus.pc == HALT_PC);
        else
            halt_hit = pc_same && (stb_q == STB_W'(HALT_CYCLES - 1));
    end

    always_comb begin
        nxt       = st;
        start_acc = 1'b0;
        case (st)
            IDLE, DONE, TIMEOUT: begin
                if (bus.start) begin
                    nxt       = HOLD;
                    start_acc = 1'b1;
                end
            end
            HOLD:    if (hold_end) nxt = RUN;
            RUN: begin
                if (halt_hit)        nxt = DONE;
                else if (budget_hit) nxt = TIMEOUT;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st           <= IDLE;
            prev_pc      <= '0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            st           <= nxt;
            if (in_run) prev_pc <= bus.pc;
            core_reset_q <= (nxt != RUN);
            running_q    <= (nxt == RUN);
            done_q       <= (nxt == DONE);
            timeout_q    <= (nxt == TIMEOUT);
        end
    end

    sat_counter #(.W(HOLD_W)) u_hold (
        .clk(clk), .reset(reset), .clr(start_acc), .en(in_hold), .q(hold_q)
    );

    sat_counter #(.W(STB_W)) u_stable (
        .clk(clk), .reset(reset),
        .clr(start_acc || (in_run && !pc_same)),
        .en(in_run && pc_same), .q(stb_q)
    );

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk(clk), .reset(reset), .clr(start_acc), .en(in_run), .q(cyc_q)
    );

    sat_counter #(.W(CNT_W)) u_retired (
        .clk(clk), .reset(reset), .clr(start_acc), .en(in_run && bus.retire), .q(ret_q)
    );

    assign bus.core_reset    = core_reset_q;
    assign bus.running       = running_q;
    assign bus.done          = done_q;
    assign bus.timeout       = timeout_q;
    assign bus.cycle_count   = cyc_q;
    assign bus.retired_count = ret_q;
endmodule

// File: tb/tb_run_controller.sv
// Randomized bench for run_controller: a PC-stable instance and a halt-PC instance against an outcome model.
module tb_run_controller;
    import run_ctrl_pkg::*;

    localparam int          RC    = 2;
    localparam int          A_HC  = 4;
    localparam int          A_MAX = 5000;
    localparam int          B_MAX = 10;
    localparam logic [31:0] B_HPC = 32'h1C;
    localparam int          ARR   = 64;

    typedef struct packed {
        logic        cr;
        logic        rn;
        logic        dn;
        logic        to;
        logic [31:0] cc;
        logic [31:0] rt;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a, start_b, retire;
    logic [31:0] pc;

    always #5 clk = ~clk;

    run_controller_if #(.PC_W(32), .CNT_W(32)) ifa ();
    run_controller_if #(.PC_W(32), .CNT_W(32)) ifb ();

    assign ifa.start  = start_a;
    assign ifa.pc     = pc;
    assign ifa.retire = retire;
    assign ifb.start  = start_b;
    assign ifb.pc     = pc;
    assign ifb.retire = retire;

    run_controller #(
        .PC_W(32), .CNT_W(32), .RESET_CYCLES(RC), .MAX_CYCLES(A_MAX),
        .HALT_MODE(MODE_PC_STABLE), .HALT_CYCLES(A_HC), .HALT_PC(32'h0)
    ) u_a (.clk(clk), .reset(reset), .bus(ifa));

    run_controller #(
        .PC_W(32), .CNT_W(32), .RESET_CYCLES(RC), .MAX_CYCLES(B_MAX),
        .HALT_MODE(MODE_HALT_PC), .HALT_CYCLES(A_HC), .HALT_PC(B_HPC)
    ) u_b (.clk(clk), .reset(reset), .bus(ifb));

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] spc  [ARR];
    bit          sret [ARR];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic obs_t get_obs(input bit b);
        obs_t o;
        o.cr = b ? ifb.core_reset    : ifa.core_reset;
        o.rn = b ? ifb.running       : ifa.running;
        o.dn = b ? ifb.done          : ifa.done;
        o.to = b ? ifb.timeout       : ifa.timeout;
        o.cc = b ? ifb.cycle_count   : ifa.cycle_count;
        o.rt = b ? ifb.retired_count : ifa.retired_count;
        return o;
    endfunction

    task automatic chk_all(input string tag, input bit b, input bit cr, input bit rn,
                           input bit dn, input bit to, input int cc, input int rt);
        obs_t o;
        o = get_obs(b);
        chk({tag, ".core_reset"}, 32'(o.cr), 32'(cr));
        chk({tag, ".running"},    32'(o.rn), 32'(rn));
        chk({tag, ".done"},       32'(o.dn), 32'(dn));
        chk({tag, ".timeout"},    32'(o.to), 32'(to));
        chk({tag, ".cycles"},     o.cc,      32'(cc));
        chk({tag, ".retired"},    o.rt,      32'(rt));
    endtask

    // Outcome of one run from the per-RUN-cycle stimulus: RUN cycles spent,
    // instructions retired, and whether it ended by halt (1) or budget (0).
    task automatic predict(input bit b, output int n, output int r, output bit d);
        int stable;
        stable = 0;
        n = 0;
        r = 0;
        d = 1'b0;
        for (int k = 0; k < ARR; k++) begin
            n++;
            r += int'(sret[k]);
            if (!b) begin
                stable = (k > 0 && spc[k] == spc[k-1]) ? stable + 1 : 0;
                if (stable >= A_HC) begin d = 1'b1; return; end
                if (n >= A_MAX) return;
            end else begin
                if (sret[k] && spc[k] == B_HPC) begin d = 1'b1; return; end
                if (n >= B_MAX) return;
            end
        end
    endtask

    task automatic gen_a_rand();
        int          len;
        logic [31:0] tail;
        len  = int'($urandom_range(1, 40));
        tail = 32'h200 + 32'($urandom_range(0, 3));
        for (int k = 0; k < ARR; k++) begin
            spc[k]  = (k < len) ? 32'h200 + 32'($urandom_range(0, 3)) : tail;
            sret[k] = bit'($urandom_range(0, 1));
        end
    endtask

    task automatic gen_b_rand();
        for (int k = 0; k < ARR; k++) begin
            spc[k]  = 32'h18 + 32'($urandom_range(0, 3)) * 32'd4;
            sret[k] = bit'($urandom_range(0, 1));
        end
    endtask

    task automatic gen_ramp(input logic [31:0] base, input bit all_ret);
        for (int k = 0; k < ARR; k++) begin
            spc[k]  = base + 32'(k) * 32'd4;
            sret[k] = all_ret ? 1'b1 : bit'($urandom_range(0, 1));
        end
    endtask

    // Cycle t=0 drives start; t=1..RC is HOLD, then n RUN cycles, then the end state.
    // Inputs outside RUN are junk and extra start pulses land only in HOLD/RUN.
    task automatic run_one(input string tag, input bit b, input int abort_k);
        int n, r, rt, k;
        bit d, s;
        predict(b, n, r, d);
        rt = 0;
        for (int t = 0; t <= RC + n + 3; t++) begin
            @(negedge clk);
            if (t >= 1 && t <= RC)
                chk_all({tag, ".hold"}, b, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
            else if (t > RC && t <= RC + n) begin
                k = t - RC - 1;
                chk_all({tag, ".run"}, b, 1'b0, 1'b1, 1'b0, 1'b0, k, rt);
                rt += int'(sret[k]);
            end else if (t > RC + n)
                chk_all({tag, ".end"}, b, 1'b1, 1'b0, d, !d, n, r);

            if (t > RC && t <= RC + n) begin
                k      = t - RC - 1;
                pc     = spc[k];
                retire = sret[k];
            end else begin
                pc     = $urandom;
                retire = 1'($urandom_range(0, 1));
            end
            s = (t == 0) || (t >= 1 && t <= RC + n && $urandom_range(0, 5) == 0);

            if (abort_k >= 0 && t == RC + 1 + abort_k) begin
                start_a = 1'b0;
                start_b = 1'b0;
                #2 reset = 1'b1;
                #1;
                chk_all({tag, ".async_a"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
                chk_all({tag, ".async_b"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
                #1 reset = 1'b0;
                return;
            end
            if (b) start_b = s;
            else   start_a = s;
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        obs_t o;
        start_a = 1'b0;
        start_b = 1'b0;
        pc      = 32'h0;
        retire  = 1'b0;

        repeat (2) begin
            @(negedge clk);
            chk_all("rst_a", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
            chk_all("rst_b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_all("idle_a", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
            pc     = $urandom;
            retire = 1'b1;
        end

        // pc ramps for 20 RUN cycles, then parks at 0x40
        for (int k = 0; k < ARR; k++) begin
            spc[k]  = (k < 20) ? 32'h1000 + 32'(k) * 32'd4 : 32'h40;
            sret[k] = bit'($urandom_range(0, 1));
        end
        run_one("freeze", 1'b0, -1);
        o = get_obs(1'b0);
        chk("freeze.cycles_lit", o.cc, 32'd25);
        chk("freeze.done_lit", 32'(o.dn), 32'd1);

        for (int i = 0; i < 6; i++) begin
            gen_a_rand();
            run_one("rand_a", 1'b0, -1);
        end

        gen_ramp(32'h0, 1'b1);
        run_one("haltpc", 1'b1, -1);
        o = get_obs(1'b1);
        chk("haltpc.retired_lit", o.rt, 32'd8);
        chk("haltpc.done_lit", 32'(o.dn), 32'd1);

        gen_ramp(32'h100, 1'b0);
        run_one("budget", 1'b1, -1);
        o = get_obs(1'b1);
        chk("budget.cycles_lit", o.cc, 32'd10);
        chk("budget.timeout_lit", 32'(o.to), 32'd1);
        chk("budget.done_lit", 32'(o.dn), 32'd0);

        gen_ramp(32'h100, 1'b0);
        spc[9]  = B_HPC;
        sret[9] = 1'b1;
        run_one("tie", 1'b1, -1);
        o = get_obs(1'b1);
        chk("tie.done_lit", 32'(o.dn), 32'd1);
        chk("tie.timeout_lit", 32'(o.to), 32'd0);

        for (int i = 0; i < 8; i++) begin
            gen_b_rand();
            run_one("rand_b", 1'b1, -1);
        end

        gen_ramp(32'h3000, 1'b0);
        run_one("abort", 1'b0, 6);
        repeat (3) begin
            @(negedge clk);
            chk_all("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
            pc     = $urandom;
            retire = 1'b1;
        end
        gen_a_rand();
        run_one("relaunch", 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter PC_W, default 32, width of the monitored program counter.
REQ-002 Parameter CNT_W, default 32, width of the cycle and retire counters.
REQ-003 Parameter RESET_CYCLES, default 2, number of cycles core_reset is held after start; legal range 1..255.
REQ-004 Parameter MAX_CYCLES, default 5000, run-cycle budget before timeout; must be below 2^CNT_W.
REQ-005 Parameter HALT_MODE, default 0; 0 selects PC-stable halt detection, 1 selects halt-PC match.
REQ-006 Parameter HALT_CYCLES, default 4, consecutive unchanged-PC cycles that signal a halt in mode 0.
REQ-007 Parameter HALT_PC, default 0, retiring PC that signals a halt in mode 1.
REQ-008 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-009 Port reset, input, 1, asynchronous active-high reset.
REQ-010 Port start, input, 1, single-cycle request to (re)launch the core.
REQ-011 Port pc, input, PC_W, current core program counter.
REQ-012 Port retire, input, 1, one instruction retired this cycle.
REQ-013 Port core_reset, output, 1, registered reset driven to the processor core.
REQ-014 Port running, output, 1, high while in RUN.
REQ-015 Ports done and timeout, outputs, 1 each, sticky completion flags.
REQ-016 Ports cycle_count and retired_count, outputs, CNT_W each, run statistics.

Function
REQ-017 FSM states: IDLE, HOLD, RUN, DONE, TIMEOUT; all outputs registered.
REQ-018 IDLE: core_reset=1; start -> HOLD; both counters and both flags clear on that edge.
REQ-019 HOLD: core_reset=1 for exactly RESET_CYCLES cycles, counted from entry, then -> RUN.
REQ-020 RUN: core_reset=0, running=1; cycle_count +1 per RUN cycle; retired_count +1 per cycle with retire=1.
REQ-021 Counters saturate at all-ones and never wrap.
REQ-022 Mode 0: prev_pc is captured every RUN cycle; the stable counter increments when pc==prev_pc and clears otherwise; the first RUN cycle counts as not stable.
REQ-023 Mode 0: when the stable counter reaches HALT_CYCLES -> DONE on the next edge.
REQ-024 Mode 1: retire=1 with pc==HALT_PC -> DONE on the next edge; that retire is counted.
REQ-025 When cycle_count reaches MAX_CYCLES -> TIMEOUT on the next edge.
REQ-026 If a halt and the budget are both hit in the same cycle, DONE wins and timeout stays 0.
REQ-027 DONE and TIMEOUT: core_reset=1, running=0, counters frozen, done/timeout held high.
REQ-028 start in DONE or TIMEOUT -> HOLD, with counters and flags cleared, exactly as from IDLE.
REQ-029 start in HOLD or RUN is ignored.
REQ-030 retire and pc are ignored outside RUN.

Reset
REQ-031 Asserting reset at any time, including mid-RUN, SHALL immediately force IDLE, core_reset=1, running=0, done=0, timeout=0, all counters=0, and the stable counter and prev_pc to 0.
REQ-032 After reset deasserts, the block SHALL stay in IDLE until start.

Structure
REQ-033 A shared package run_ctrl_pkg SHALL hold the state enum and the HALT_MODE constants (MODE_PC_STABLE=0, MODE_HALT_PC=1).
REQ-034 One sub-module sat_counter (parameter W; inputs clr and en; saturating output) SHALL be instantiated for cycle_count, retired_count and the hold/stable counters.

Verification
REQ-035 Defaults, reset then start at cycle 3 -> core_reset high for 2 cycles after start, running rises in the next cycle.
REQ-036 Mode 0, pc incrementing for 20 RUN cycles then constant 0x40 -> done=1 on the 5th cycle after pc freezes; cycle_count frozen.
REQ-037 Mode 1 with HALT_PC=0x1C, retire every cycle, halt PC reached on RUN cycle 8 -> done=1 on the next edge, retired_count=8.
REQ-038 MAX_CYCLES=10, pc always changing -> timeout=1 with cycle_count=10 and done=0; a following start clears the flags and relaunches.
REQ-039 MAX_CYCLES=10, halt condition true on RUN cycle 10 -> done=1 and timeout=0.
REQ-040 reset pulsed mid-RUN at cycle 7 -> outputs return to reset values immediately, without waiting for a clock edge; start during RUN is ignored.
